ntt_pass_sequencer: RTL

Controller that sequences the SIZE-lane butterfly array through a complete transform. It issues row reads to the coefficient banks, drives the array's mode, swap and twiddle index in step with the arriving data, and issues the matching write-backs after the array's pipeline latency. Between passes it drains the pipeline to avoid read-after-write hazards. It sits between the top-level command interface and the bank memories plus the butterfly array.

---
 rtl/ntt_pass_sequencer_if.sv | 42 ++++
 rtl/ntt_pass_sequencer.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/ntt_pass_sequencer_if.sv
// Bundle between the NTT pass sequencer and its surroundings: the command
// side (start/cmd/w_base/hold -> busy/done/cfg_err) plus the bank and
// butterfly-array control outputs. The sequencer takes the master modport,
// the command source / memory side takes the slave modport.
interface ntt_pass_sequencer_if #(
  parameter int LUT_SIZE = 1360,
  parameter int DEPTH    = 64,
  parameter int STAGES   = 7
);
  localparam int W_IDX_W = $clog2(LUT_SIZE);
  localparam int ADDR_W  = $clog2(DEPTH);
  localparam int PASS_W  = $clog2(STAGES + 1);

  logic               start;
  logic               cmd;
  logic               cmd_swap;
  logic [W_IDX_W-1:0] w_base;
  logic               hold;
  logic               busy;
  logic               done;
  logic               cfg_err;
  logic [PASS_W-1:0]  stage;
  logic               rd_en;
  logic [ADDR_W-1:0]  rd_addr;
  logic               mode;
  logic               swap;
  logic [W_IDX_W-1:0] w_idx;
  logic               wr_en;
  logic [ADDR_W-1:0]  wr_addr;

  modport master (
    input  start, cmd, cmd_swap, w_base, hold,
    output busy, done, cfg_err, stage, rd_en, rd_addr,
           mode, swap, w_idx, wr_en, wr_addr
  );

  modport slave (
    output start, cmd, cmd_swap, w_base, hold,
    input  busy, done, cfg_err, stage, rd_en, rd_addr,
           mode, swap, w_idx, wr_en, wr_addr
  );
endinterface

// File: rtl/ntt_pass_sequencer.sv
// Sequences the butterfly array through a full transform: issues bank row
// reads, drives mode/swap/twiddle index one cycle after each read, and
// issues the matching write-back BF_LAT cycles later. Between passes it
// waits for the last write of the pass so the next pass never reads a row
// before it has been written back.
module ntt_pass_sequencer #(
  parameter int SIZE     = 128,
  parameter int LUT_SIZE = 1360,
  parameter int DEPTH    = 64,
  parameter int STAGES   = 7,
  parameter int BF_LAT   = 4
) (
  input logic                  clk,
  input logic                  reset,
  ntt_pass_sequencer_if.master bus
);
  localparam int W_IDX_W = $clog2(LUT_SIZE);
  localparam int ADDR_W  = $clog2(DEPTH);
  localparam int PASS_W  = $clog2(STAGES + 1);
  localparam int SUM_W   = W_IDX_W + $clog2(STAGES * DEPTH + 1);

  localparam logic [SUM_W-1:0]  NTT_SPAN = SUM_W'(STAGES * DEPTH);
  localparam logic [SUM_W-1:0]  MUL_SPAN = SUM_W'(DEPTH);
  localparam logic [SUM_W-1:0]  LUT_LIM  = SUM_W'(LUT_SIZE);
  localparam logic [ADDR_W-1:0] LAST_B   = ADDR_W'(DEPTH - 1);
  localparam logic [PASS_W-1:0] LAST_P   = PASS_W'(STAGES - 1);

  // Parameter sanity: a pass needs at least two beats and the array at
  // least one pipeline stage.
  if (DEPTH < 2 || BF_LAT < 1 || SIZE < 1) begin : g_param_check
    $error("ntt_pass_sequencer: DEPTH>=2, BF_LAT>=1, SIZE>=1 required");
  end

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

  state_t             state_q;
  logic               busy_q, done_q, cfg_err_q;
  logic [PASS_W-1:0]  p_q;
  logic [ADDR_W-1:0]  b_q;
  logic               rd_en_q;
  logic [ADDR_W-1:0]  rd_addr_q;
  logic               cmd_q, cswap_q;
  logic [W_IDX_W-1:0] w_cnt_q;
  logic               mode_q, swap_q;
  logic [W_IDX_W-1:0] w_idx_q;
  logic [BF_LAT:0]    wv_q;
  logic [ADDR_W-1:0]  wa_q [BF_LAT+1];

  logic [SUM_W-1:0]   cfg_span;
  logic               cfg_bad;
  logic [PASS_W-1:0]  last_pass;

  // Twiddle-range check for an incoming command, done at full width so the
  // sum never wraps.
  always_comb begin
    cfg_span = NTT_SPAN;
    if (bus.cmd) begin
      cfg_span = MUL_SPAN;
    end else begin
      cfg_span = NTT_SPAN;
    end
    cfg_bad = (SUM_W'(bus.w_base) + cfg_span) > LUT_LIM;
    if (cmd_q) begin
      last_pass = PASS_W'(0);
    end else begin
      last_pass = LAST_P;
    end
  end

  // Control FSM: command accept, read issue with hold, pass drain, done.
  // w_cnt_q advances once per issued beat, one cycle behind the read, so it
  // always holds w_base + p*DEPTH + b for the next beat to reach the array.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      cfg_err_q <= 1'b0;
      p_q       <= '0;
      b_q       <= '0;
      rd_en_q   <= 1'b0;
      rd_addr_q <= '0;
      cmd_q     <= 1'b0;
      cswap_q   <= 1'b0;
      w_cnt_q   <= '0;
    end else begin
      done_q    <= 1'b0;
      cfg_err_q <= 1'b0;
      rd_en_q   <= 1'b0;
      if (rd_en_q) begin
        w_cnt_q <= w_cnt_q + W_IDX_W'(1);
      end
      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            if (cfg_bad) begin
              cfg_err_q <= 1'b1;
            end else begin
              cmd_q   <= bus.cmd;
              cswap_q <= bus.cmd_swap;
              w_cnt_q <= bus.w_base;
              b_q     <= '0;
              p_q     <= '0;
              busy_q  <= 1'b1;
              state_q <= S_ISSUE;
            end
          end
        end
        S_ISSUE: begin
          if (!bus.hold) begin
            rd_en_q   <= 1'b1;
            rd_addr_q <= b_q;
            if (b_q == LAST_B) begin
              b_q     <= '0;
              state_q <= S_DRAIN;
            end else begin
              b_q <= b_q + ADDR_W'(1);
            end
          end
        end
        S_DRAIN: begin
          if (wv_q[BF_LAT] && (wa_q[BF_LAT] == LAST_B)) begin
            if (p_q == last_pass) begin
              p_q     <= '0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end else begin
              p_q     <= p_q + PASS_W'(1);
              b_q     <= '0;
              state_q <= S_ISSUE;
            end
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // Array-side controls for the beat whose bank data arrives this cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mode_q  <= 1'b0;
      swap_q  <= 1'b0;
      w_idx_q <= '0;
    end else if (rd_en_q) begin
      mode_q  <= cmd_q;
      swap_q  <= cmd_q & cswap_q;
      w_idx_q <= w_cnt_q;
    end
  end

  // Fixed-length write-back pipeline; deliberately blind to hold so that
  // beats already in flight always complete.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wv_q <= '0;
      for (int k = 0; k <= BF_LAT; k++) begin
        wa_q[k] <= '0;
      end
    end else begin
      wv_q    <= {wv_q[BF_LAT-1:0], rd_en_q};
      wa_q[0] <= rd_addr_q;
      for (int k = 1; k <= BF_LAT; k++) begin
        wa_q[k] <= wa_q[k-1];
      end
    end
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.cfg_err = cfg_err_q;
  assign bus.stage   = p_q;
  assign bus.rd_en   = rd_en_q;
  assign bus.rd_addr = rd_addr_q;
  assign bus.mode    = mode_q;
  assign bus.swap    = swap_q;
  assign bus.w_idx   = w_idx_q;
  assign bus.wr_en   = wv_q[BF_LAT];
  assign bus.wr_addr = wa_q[BF_LAT];
endmodule
